// File: rtl/smol_pkg.sv
// smol_pkg: shared definitions for the SmolCore decode stage.
//   - RV32I opcode / funct7 constants used by the decoder
//   - op_sel_e: ALU operation encoding (values 0..19)
//   - decode_bundle_t: everything the decode stage hands to execute,
//     except the valid flag
// Widths are fixed here. smol_decode_stage's PC_W / OP_W parameters
// default to these values and must stay equal to them.
package smol_pkg;

   localparam int SMOL_PC_W = 5;
   localparam int SMOL_OP_W = 5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [SMOL_OP_W-1:0] {
      OP_ADD   = 5'd0,
      OP_SUB   = 5'd1,
      OP_AND   = 5'd2,
      OP_OR    = 5'd3,
      OP_XOR   = 5'd4,
      OP_SRL   = 5'd5,
      OP_SLL   = 5'd6,
      OP_SLTU  = 5'd7,
      OP_LUI   = 5'd8,
      OP_AUIPC = 5'd9,
      OP_JUMP  = 5'd10,
      OP_SLT   = 5'd11,
      OP_SRA   = 5'd12,
      OP_MEM   = 5'd13,
      OP_BEQ   = 5'd14,
      OP_BNE   = 5'd15,
      OP_BLT   = 5'd16,
      OP_BGE   = 5'd17,
      OP_BLTU  = 5'd18,
      OP_BGEU  = 5'd19
   } op_sel_e;

   typedef struct packed {
      op_sel_e              op_sel;
      logic [4:0]           rs1_idx;
      logic [4:0]           rs2_idx;
      logic [4:0]           rd_idx;
      logic                 rd_we;
      logic [31:0]          imm;
      logic                 use_imm;
      logic                 is_load;
      logic                 is_store;
      logic                 is_branch;
      logic                 is_jump;
      logic                 illegal;
      logic [SMOL_PC_W-1:0] pc;
   } decode_bundle_t;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/smol_inst_decode.sv
// smol_inst_decode: purely combinational RV32I decoder.
// Ports:
//   instr  in  32               raw instruction word
//   bundle out decode_bundle_t  decoded fields (pc field left 0; the
//                               stage fills it from its own pc input)
// Register index fields are passed through raw for every format.
// Illegal encodings produce op_sel=ADD, rd_we=0, imm=0, use_imm=0, no
// class flags, illegal=1.
module smol_inst_decode
   import smol_pkg::*;
(
   input  logic [31:0]    instr,
   output decode_bundle_t bundle
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign imm_i = sext12(instr[31:20]);
   assign imm_s = sext12({instr[31:25], instr[11:7]});
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   op_sel_e     op;
   logic        legal;
   logic        is_imm;
   logic        f7_plain_ok;
   logic        rd_we;
   logic        use_imm;
   logic [31:0] imm;
   logic        is_load, is_store, is_branch, is_jump;

   // NOTE: every variable gets a default before the case so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      op          = OP_ADD;
      legal       = 1'b1;
      is_imm      = (opcode == OPC_OP_IMM);
      // OP-IMM ignores funct7 except for shifts; OP demands zero funct7
      // for every non-add/sub/shift operation.
      f7_plain_ok = is_imm || (funct7 == F7_BASE);
      rd_we       = 1'b0;
      use_imm     = 1'b0;
      imm         = '0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      is_branch   = 1'b0;
      is_jump     = 1'b0;

      case (opcode)
         OPC_OP, OPC_OP_IMM: begin
            rd_we   = 1'b1;
            use_imm = is_imm;
            imm     = is_imm ? imm_i : '0;
            case (funct3)
               3'b000: begin
                  if (is_imm || funct7 == F7_BASE) op = OP_ADD;
                  else if (funct7 == F7_ALT)       op = OP_SUB;
                  else                             legal = 1'b0;
               end
               3'b001: begin
                  if (funct7 == F7_BASE) op = OP_SLL;
                  else                   legal = 1'b0;
               end
               3'b101: begin
                  if (funct7 == F7_BASE)     op = OP_SRL;
                  else if (funct7 == F7_ALT) op = OP_SRA;
                  else                       legal = 1'b0;
               end
               3'b111:  begin op = OP_AND;  legal = f7_plain_ok; end
               3'b110:  begin op = OP_OR;   legal = f7_plain_ok; end
               3'b100:  begin op = OP_XOR;  legal = f7_plain_ok; end
               3'b011:  begin op = OP_SLTU; legal = f7_plain_ok; end
               default: begin op = OP_SLT;  legal = f7_plain_ok; end
            endcase
         end
         OPC_LUI: begin
            op = OP_LUI;   rd_we = 1'b1; use_imm = 1'b1; imm = imm_u;
         end
         OPC_AUIPC: begin
            op = OP_AUIPC; rd_we = 1'b1; use_imm = 1'b1; imm = imm_u;
         end
         OPC_JAL: begin
            op = OP_JUMP;  rd_we = 1'b1; use_imm = 1'b1; imm = imm_j; is_jump = 1'b1;
         end
         OPC_JALR: begin
            op = OP_JUMP;  rd_we = 1'b1; use_imm = 1'b1; imm = imm_i; is_jump = 1'b1;
            legal = (funct3 == 3'b000);
         end
         OPC_LOAD: begin
            op = OP_MEM;   rd_we = 1'b1; use_imm = 1'b1; imm = imm_i; is_load = 1'b1;
         end
         OPC_STORE: begin
            op = OP_MEM;   use_imm = 1'b1; imm = imm_s; is_store = 1'b1;
         end
         OPC_BRANCH: begin
            imm       = imm_b;
            is_branch = 1'b1;
            case (funct3)
               3'b000:  op = OP_BEQ;
               3'b001:  op = OP_BNE;
               3'b100:  op = OP_BLT;
               3'b101:  op = OP_BGE;
               3'b110:  op = OP_BLTU;
               3'b111:  op = OP_BGEU;
               default: legal = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase

      bundle         = '0;
      bundle.rs1_idx = instr[19:15];
      bundle.rs2_idx = instr[24:20];
      bundle.rd_idx  = instr[11:7];
      bundle.illegal = !legal;
      if (legal) begin
         bundle.op_sel    = op;
         // Writes to x0 are architecturally discarded; drop them here.
         bundle.rd_we     = rd_we && (instr[11:7] != 5'd0);
         bundle.imm       = imm;
         bundle.use_imm   = use_imm;
         bundle.is_load   = is_load;
         bundle.is_store  = is_store;
         bundle.is_branch = is_branch;
         bundle.is_jump   = is_jump;
      end
   end

endmodule

// File: rtl/smol_decode_stage.sv
// smol_decode_stage: RV32I decode/issue stage in front of the SmolCore ALU.
// Accepts instr+pc on a valid/ready handshake, decodes through
// smol_inst_decode and holds the result in an output register (1-cycle
// latency, 1 instr/cycle, backpressure, synchronous flush).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 kill held and in-flight instruction
//   in_valid/in_ready     fetch handshake; in_instr, in_pc payload
//   out_valid/out_ready   execute handshake
//   out_op_sel .. out_pc  decoded bundle fields
// Build option: define SMOL_DECODE_SKID_EN to add a one-entry skid buffer;
// in_ready is then a registered "skid empty" flag. Without it in_ready is
// combinational: !flush && (!out_valid || out_ready), and 0 in reset.
module smol_decode_stage
   import smol_pkg::*;
#(
   parameter int PC_W = SMOL_PC_W,
   parameter int OP_W = SMOL_OP_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OP_W-1:0] out_op_sel,
   output logic [4:0]      out_rs1_idx,
   output logic [4:0]      out_rs2_idx,
   output logic [4:0]      out_rd_idx,
   output logic            out_rd_we,
   output logic [31:0]     out_imm,
   output logic            out_use_imm,
   output logic            out_is_load,
   output logic            out_is_store,
   output logic            out_is_branch,
   output logic            out_is_jump,
   output logic            out_illegal,
   output logic [PC_W-1:0] out_pc
);

   decode_bundle_t dec_raw, dec_bundle, out_q;
   logic           accept;

   smol_inst_decode u_dec (
      .instr  (in_instr),
      .bundle (dec_raw)
   );

   always_comb begin
      dec_bundle    = dec_raw;
      dec_bundle.pc = in_pc;
   end

`ifdef SMOL_DECODE_SKID_EN
   decode_bundle_t skid_q;
   logic           skid_valid;
   logic           ready_q;

   assign in_ready = ready_q;
   assign accept   = in_valid && ready_q && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_q      <= '0;
         skid_valid <= 1'b0;
         skid_q     <= '0;
         ready_q    <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
      end else if (!out_valid || out_ready) begin
         // Output slot frees up: skid content goes first to keep order.
         // ready_q is low while the skid is full, so accept and a full
         // skid never coincide.
         ready_q <= 1'b1;
         if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            out_q     <= dec_bundle;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_q     <= dec_bundle;
         skid_valid <= 1'b1;
         ready_q    <= 1'b0;
      end
   end
`else
   // rst_n gates in_ready so fetch sees "not ready" for the whole reset.
   assign in_ready = rst_n && !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // NOTE: state updates use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   // NOTE: the payload register is reset too, so outputs read all-zero
   // during and right after reset rather than stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_q     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_q     <= dec_bundle;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
`endif

   assign out_op_sel    = out_q.op_sel;
   assign out_rs1_idx   = out_q.rs1_idx;
   assign out_rs2_idx   = out_q.rs2_idx;
   assign out_rd_idx    = out_q.rd_idx;
   assign out_rd_we     = out_q.rd_we;
   assign out_imm       = out_q.imm;
   assign out_use_imm   = out_q.use_imm;
   assign out_is_load   = out_q.is_load;
   assign out_is_store  = out_q.is_store;
   assign out_is_branch = out_q.is_branch;
   assign out_is_jump   = out_q.is_jump;
   assign out_illegal   = out_q.illegal;
   assign out_pc        = out_q.pc;

endmodule

// File: tb/tb_smol_decode_stage.sv
// Self-checking bench for smol_decode_stage (default build, no skid).
// Expected bundles are hand-derived constants pushed to a scoreboard queue
// on each accepted input and compared when the DUT hands a bundle on.
module tb_smol_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [4:0]  in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_op_sel;
   logic [4:0]  out_rs1_idx, out_rs2_idx, out_rd_idx;
   logic        out_rd_we;
   logic [31:0] out_imm;
   logic        out_use_imm;
   logic        out_is_load, out_is_store, out_is_branch, out_is_jump;
   logic        out_illegal;
   logic [4:0]  out_pc;

   smol_decode_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_op_sel    (out_op_sel),
      .out_rs1_idx   (out_rs1_idx),
      .out_rs2_idx   (out_rs2_idx),
      .out_rd_idx    (out_rd_idx),
      .out_rd_we     (out_rd_we),
      .out_imm       (out_imm),
      .out_use_imm   (out_use_imm),
      .out_is_load   (out_is_load),
      .out_is_store  (out_is_store),
      .out_is_branch (out_is_branch),
      .out_is_jump   (out_is_jump),
      .out_illegal   (out_illegal),
      .out_pc        (out_pc)
   );

   always #5 clk = ~clk;

   // flags = {is_load, is_store, is_branch, is_jump, illegal}
   typedef struct {
      logic [31:0] instr;
      logic [4:0]  pc;
      logic [4:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] imm;
      logic        use_imm;
      logic [4:0]  flags;
      bit          chk_rs;
      bit          chk_imm;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];
   vec_t exp_q [$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int acc_cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input logic [31:0] instr, input logic [4:0] pc,
                               input logic [4:0] op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic we, input logic [31:0] imm,
                               input logic use_imm, input logic [4:0] flags,
                               input bit chk_rs, input bit chk_imm);
      vec_t v;
      v.instr = instr; v.pc = pc; v.op = op; v.rs1 = rs1; v.rs2 = rs2;
      v.rd = rd; v.we = we; v.imm = imm; v.use_imm = use_imm;
      v.flags = flags; v.chk_rs = chk_rs; v.chk_imm = chk_imm;
      return v;
   endfunction

   task automatic init_vecs();
      //              instr         pc  op  rs1 rs2 rd  we imm           ui flags     rs imm
      vecs[0]  = mk(32'h002081B3, 0,  0,  1,  2,  3,  1, 32'h0,        0, 5'b00000, 1, 0); // add x3,x1,x2
      vecs[1]  = mk(32'hFFF00293, 1,  0,  0,  0,  5,  1, 32'hFFFFFFFF, 1, 5'b00000, 0, 1); // addi x5,x0,-1
      vecs[2]  = mk(32'h4020D1B3, 2,  12, 1,  2,  3,  1, 32'h0,        0, 5'b00000, 1, 0); // sra
      vecs[3]  = mk(32'h00208463, 4,  14, 1,  2,  8,  0, 32'h8,        0, 5'b00100, 1, 1); // beq +8
      vecs[4]  = mk(32'hFFFFFFFF, 5,  0,  0,  0,  0,  0, 32'h0,        0, 5'b00001, 0, 0); // illegal
      vecs[5]  = mk(32'h00000013, 6,  0,  0,  0,  0,  0, 32'h0,        1, 5'b00000, 0, 1); // addi x0 (rd_we forced 0)
      vecs[6]  = mk(32'h123450B7, 7,  8,  0,  0,  1,  1, 32'h12345000, 1, 5'b00000, 0, 1); // lui
      vecs[7]  = mk(32'hFE20AE23, 8,  13, 1,  2,  28, 0, 32'hFFFFFFFC, 1, 5'b01000, 1, 1); // sw x2,-4(x1)
      vecs[8]  = mk(32'h010000EF, 9,  10, 0,  0,  1,  1, 32'h10,       1, 5'b00010, 0, 1); // jal x1,+16
      vecs[9]  = mk(32'h022081B3, 10, 0,  0,  0,  0,  0, 32'h0,        0, 5'b00001, 0, 0); // mul: illegal funct7
      vecs[10] = mk(32'h0020A463, 11, 0,  0,  0,  0,  0, 32'h0,        0, 5'b00001, 0, 0); // branch f3=010 illegal
      vecs[11] = mk(32'h0080A283, 12, 13, 0,  0,  5,  1, 32'h8,        1, 5'b10000, 0, 1); // lw x5,8(x1)
      vecs[12] = mk(32'hFE20FFE3, 13, 19, 1,  2,  31, 0, 32'hFFFFFFFE, 0, 5'b00100, 1, 1); // bgeu -2
      vecs[13] = mk(32'h00001097, 14, 9,  0,  0,  1,  1, 32'h1000,     1, 5'b00000, 0, 1); // auipc x1,1
      vecs[14] = mk(32'h40109093, 15, 0,  0,  0,  0,  0, 32'h0,        0, 5'b00001, 0, 0); // slli bad funct7
      vecs[15] = mk(32'h4010D093, 16, 12, 0,  0,  1,  1, 32'h0,        1, 5'b00000, 0, 0); // srai x1,x1,1
   endtask

   // Scoreboard consumer: a handshake is visible at the negedge before the
   // edge that completes it.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL mon_unexpected got pc=%0d op=%0d exp=no bundle", out_pc, out_op_sel);
         end else begin
            vec_t e;
            e = exp_q.pop_front();
            checks++;
            if (out_pc !== e.pc) begin
               failures++; $display("FAIL mon_pc got=%0d exp=%0d", out_pc, e.pc);
            end
            checks++;
            if (out_op_sel !== e.op) begin
               failures++; $display("FAIL mon_op pc=%0d got=%0d exp=%0d", e.pc, out_op_sel, e.op);
            end
            checks++;
            if (out_rd_we !== e.we) begin
               failures++; $display("FAIL mon_rd_we pc=%0d got=%0b exp=%0b", e.pc, out_rd_we, e.we);
            end
            checks++;
            if ({out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal} !== e.flags) begin
               failures++;
               $display("FAIL mon_flags pc=%0d got=%05b exp=%05b", e.pc,
                        {out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal}, e.flags);
            end
            if (!e.flags[0]) begin
               checks++;
               if (out_rd_idx !== e.rd) begin
                  failures++; $display("FAIL mon_rd pc=%0d got=%0d exp=%0d", e.pc, out_rd_idx, e.rd);
               end
               checks++;
               if (out_use_imm !== e.use_imm) begin
                  failures++; $display("FAIL mon_use_imm pc=%0d got=%0b exp=%0b", e.pc, out_use_imm, e.use_imm);
               end
            end
            if (e.chk_rs) begin
               checks++;
               if ({out_rs1_idx, out_rs2_idx} !== {e.rs1, e.rs2}) begin
                  failures++;
                  $display("FAIL mon_rs pc=%0d got=%0d,%0d exp=%0d,%0d", e.pc,
                           out_rs1_idx, out_rs2_idx, e.rs1, e.rs2);
               end
            end
            if (e.chk_imm) begin
               checks++;
               if (out_imm !== e.imm) begin
                  failures++; $display("FAIL mon_imm pc=%0d got=%h exp=%h", e.pc, out_imm, e.imm);
               end
            end
         end
      end
   end

   // Present one vector and hold it until accepted (bounded wait).
   task automatic send(input int idx);
      int waited = 0;
      in_valid = 1'b1;
      in_instr = vecs[idx].instr;
      in_pc    = vecs[idx].pc;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(vecs[idx]);
            acc_cyc = cyc;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         waited++;
         if (waited > 50) begin
            checks++; failures++;
            $display("FAIL send_timeout idx=%0d got=no accept exp=accept within 50 cycles", idx);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got=%0d pending exp=0 pending", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_handshake got valid=%0b ready=%0b exp valid=0 ready=0", out_valid, in_ready);
      end
      checks++;
      if ({out_op_sel, out_rd_idx, out_rd_we, out_imm, out_pc, out_illegal} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got op=%0d rd=%0d imm=%h pc=%0d ill=%0b exp=all zero",
                  out_op_sel, out_rd_idx, out_imm, out_pc, out_illegal);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_decode();
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) send(i);
      wait_drain("decode");
   endtask

   task automatic test_back_to_back();
      int first_acc;
      out_ready = 1'b1;
      send(0);
      first_acc = acc_cyc;
      for (int i = 1; i < 4; i++) send(i);
      checks++;
      if (acc_cyc - first_acc != 3) begin
         failures++;
         $display("FAIL b2b_throughput got=%0d cycles exp=3 cycles for 4 accepts", acc_cyc - first_acc);
      end
      wait_drain("b2b");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(3);                       // beq, pc=4, held
      in_valid = 1'b1;
      in_instr = vecs[6].instr;
      in_pc    = vecs[6].pc;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_ready cycle=%0d got=%0b exp=0", k, in_ready);
         end
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 5'd4 || out_op_sel !== 5'd14 || out_imm !== 32'h8) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d got v=%0b pc=%0d op=%0d imm=%h exp v=1 pc=4 op=14 imm=8",
                     k, out_valid, out_pc, out_op_sel, out_imm);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(6);
      send(7);
      wait_drain("bp");
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      send(0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = vecs[1].instr;
      in_pc    = vecs[1].pc;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL flush_ready got=%0b exp=0", in_ready);
      end
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid);
      end
      exp_q.delete();               // held bundle was killed
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(11);
      wait_drain("flush");
   endtask

   task automatic test_reset_mid_stall();
      out_ready = 1'b0;
      send(8);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_stall_handshake got valid=%0b ready=%0b exp 0/0", out_valid, in_ready);
      end
      checks++;
      if ({out_op_sel, out_rd_idx, out_rd_we, out_imm, out_pc, out_use_imm, out_is_jump} !== '0) begin
         failures++;
         $display("FAIL rst_stall_outputs got op=%0d rd=%0d imm=%h pc=%0d jmp=%0b exp=all zero",
                  out_op_sel, out_rd_idx, out_imm, out_pc, out_is_jump);
      end
      exp_q.delete();               // no replay after reset
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send(13);
      wait_drain("rst_stall");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      init_vecs();
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_decode();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid_stall();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
